// File: rtl/queue_pkg.sv
// Shared constants for the synchronous FIFO and its storage array.
package queue_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;
    localparam int ADDR_WIDTH         = $clog2(DEFAULT_DEPTH);
    localparam int CNT_WIDTH          = ADDR_WIDTH + 1;
endpackage

// File: rtl/queue_mem.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// registered read port; rdata is the queue's data_out.
module queue_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // A same-edge write to raddr (full queue, push+pop) returns the old word.
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/queue.sv
// Synchronous FIFO: pointers, occupancy count, registered flags and a sticky
// error bit around a queue_mem storage array.
module queue
    import queue_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;
    logic          rejected;
    logic [CW-1:0] count_next;

    // A pop at full frees the slot the simultaneous push lands in.
    always_comb begin
        pop_ok     = pop && !empty;
        push_ok    = push && (!full || pop_ok);
        rejected   = (push && !push_ok) || (pop && !pop_ok);
        count_next = count + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            error  <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(DEPTH));
            // Any rejection sets error; a clean accepted request clears it.
            if (rejected)
                error <= 1'b1;
            else if (push_ok || pop_ok)
                error <= 1'b0;
        end
    end

    queue_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (pop_ok),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_queue.sv
// Self-checking bench for queue: directed sequences plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_queue;
    import queue_pkg::*;

    localparam int DW = DEFAULT_DATA_WIDTH;
    localparam int DP = DEFAULT_DEPTH;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 push = 1'b0;
    logic                 pop = 1'b0;
    logic [DW-1:0]        data_in = '0;
    logic [DW-1:0]        data_out;
    logic                 full;
    logic                 empty;
    logic [CNT_WIDTH-1:0] count;
    logic                 error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_dout = '0;
    logic          exp_err  = 1'b0;

    queue #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle, advance the model by the FIFO rules, then compare.
    task automatic step(input logic r, input logic pu, input logic po, input logic [DW-1:0] d);
        bit pop_ok, push_ok, under, over;
        reset   = r;
        push    = pu;
        pop     = po;
        data_in = d;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            exp_dout = '0;
            exp_err  = 1'b0;
        end else begin
            pop_ok  = po && (model_q.size() > 0);
            push_ok = pu && (model_q.size() < DP || pop_ok);
            under   = po && !pop_ok;
            over    = pu && !push_ok;
            if (pop_ok)
                exp_dout = model_q.pop_front();
            if (push_ok)
                model_q.push_back(d);
            if (under || over)
                exp_err = 1'b1;
            else if (push_ok || pop_ok)
                exp_err = 1'b0;
        end
        #1;
        check("count",    32'(count),    32'(model_q.size()));
        check("empty",    32'(empty),    32'(model_q.size() == 0));
        check("full",     32'(full),     32'(model_q.size() == DP));
        check("error",    32'(error),    32'(exp_err));
        check("data_out", 32'(data_out), 32'(exp_dout));
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset held two cycles while push and pop are both requested.
        step(1, 1, 1, 8'h55);
        step(1, 1, 1, 8'h66);

        for (int i = 0; i < 16; i++) step(0, 1, 0, DW'(i));
        step(0, 1, 0, 8'hFF);                         // overflow at full
        for (int i = 0; i < 16; i++) step(0, 0, 1, '0);

        step(0, 0, 1, '0);                            // underflow at empty
        step(0, 1, 0, 8'hA5);
        step(0, 0, 1, '0);
        step(0, 1, 1, 8'h11);                         // push+pop at empty

        for (int i = 0; i < 4; i++) step(0, 1, 0, DW'(8'h20 + i));
        step(0, 1, 1, 8'h3C);                         // push+pop at count 5
        for (int i = 0; i < 11; i++) step(0, 1, 0, DW'(8'h40 + i));
        step(0, 1, 1, 8'h77);                         // push+pop at full
        for (int i = 0; i < 16; i++) step(0, 0, 1, '0);

        for (int i = 0; i < 40; i++) begin
            step(0, 1, 0, DW'(8'h80 + i));
            step(0, 0, 1, '0);
        end

        for (int i = 0; i < 3; i++) step(0, 1, 0, DW'(8'hC0 + i));
        step(1, 0, 0, '0);
        step(0, 0, 1, '0);

        // Random traffic with drifting push/pop bias to reach both full and empty.
        for (int i = 0; i < 800; i++) begin
            int bias;
            bias = ((i / 100) % 2 == 0) ? 75 : 25;
            step(($urandom_range(0, 127) == 0),
                 ($urandom_range(0, 99) < bias),
                 ($urandom_range(0, 99) < (100 - bias)),
                 DW'($urandom));
        end
        step(0, 0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
